// File: rtl/seg_scan_controller.sv
// Time-multiplexed scan controller for an 8-digit active-low 7-segment display.
// Optional macro SEG_SCAN_LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero nibble.
module seg_scan_controller #(
   parameter int TICKS_PER_DIGIT = 12500,
   parameter int BLANK_TICKS     = 250
) (
   input  logic        CLK100MHZ,
   input  logic        RST,
   input  logic [31:0] data_in,
   input  logic [7:0]  dp_in,
   input  logic [7:0]  digit_en,
   input  logic [3:0]  brightness,
   output logic [7:0]  AN,
   output logic [6:0]  SEG,
   output logic        DP,
   output logic        frame_tick
);

   // state    | meaning
   // ST_BLANK | first BLANK_TICKS cycles of a slot, all anodes off
   // ST_DRIVE | remainder of the slot, current digit may be lit (PWM gated)
   typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

   localparam int TW = $clog2(TICKS_PER_DIGIT);

   state_t          r_state, w_state_nxt;
   logic [TW-1:0]   r_tick_cnt, w_tick_nxt;
   logic [2:0]      r_slot, w_slot_nxt;
   logic [3:0]      r_pwm_cnt, w_pwm_nxt;

   logic [31:0]     r_sh_data;
   logic [7:0]      r_sh_dp;
   logic [7:0]      r_sh_en;
   logic [3:0]      r_sh_bright;

   logic [7:0]      r_an;
   logic [6:0]      r_seg;
   logic            r_dp;
   logic            r_frame_tick;

   logic            w_slot_end;
   logic            w_frame_start;
   logic [7:0]      w_en_eff;
   logic [3:0]      w_nib;
   logic            w_lit;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
      case (v)
         4'h0: hex_to_seg = 7'b1000000;
         4'h1: hex_to_seg = 7'b1111001;
         4'h2: hex_to_seg = 7'b0100100;
         4'h3: hex_to_seg = 7'b0110000;
         4'h4: hex_to_seg = 7'b0011001;
         4'h5: hex_to_seg = 7'b0010010;
         4'h6: hex_to_seg = 7'b0000010;
         4'h7: hex_to_seg = 7'b1111000;
         4'h8: hex_to_seg = 7'b0000000;
         4'h9: hex_to_seg = 7'b0010000;
         4'hA: hex_to_seg = 7'b0001000;
         4'hB: hex_to_seg = 7'b0000011;
         4'hC: hex_to_seg = 7'b1000110;
         4'hD: hex_to_seg = 7'b0100001;
         4'hE: hex_to_seg = 7'b0000110;
         default: hex_to_seg = 7'b0001110;
      endcase
   endfunction

   assign w_slot_end    = (r_tick_cnt == TW'(TICKS_PER_DIGIT - 1));
   assign w_frame_start = (r_slot == 3'd0) && (r_tick_cnt == '0);

   always_comb begin
      w_tick_nxt  = w_slot_end ? '0 : r_tick_cnt + 1'b1;
      w_slot_nxt  = w_slot_end ? r_slot + 3'd1 : r_slot;
      w_state_nxt = r_state;
      w_pwm_nxt   = '0;
      case (r_state)
         ST_BLANK: begin
            if (r_tick_cnt == TW'(BLANK_TICKS - 1)) w_state_nxt = ST_DRIVE;
         end
         ST_DRIVE: begin
            w_pwm_nxt = r_pwm_cnt + 4'd1;
            if (w_slot_end) begin
               w_state_nxt = ST_BLANK;
               w_pwm_nxt   = '0;
            end
         end
         default: w_state_nxt = ST_BLANK;
      endcase
   end

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
   // Sweep from the top digit down; a digit is eligible once any nibble at or above it is nonzero.
   always_comb begin
      logic w_nz;
      w_nz     = 1'b0;
      w_en_eff = '0;
      for (int i = 7; i >= 0; i--) begin
         w_nz        = w_nz | (|r_sh_data[4*i +: 4]);
         w_en_eff[i] = r_sh_en[i] & (w_nz | (i == 0));
      end
   end
`else
   assign w_en_eff = r_sh_en;
`endif

   assign w_nib = r_sh_data[{r_slot, 2'b00} +: 4];
   assign w_lit = (r_state == ST_DRIVE) && w_en_eff[r_slot] && (r_pwm_cnt <= r_sh_bright);

   always_ff @(posedge CLK100MHZ or posedge RST) begin
      if (RST) begin
         r_state      <= ST_BLANK;
         r_tick_cnt   <= '0;
         r_slot       <= '0;
         r_pwm_cnt    <= '0;
         r_sh_data    <= '0;
         r_sh_dp      <= '0;
         r_sh_en      <= '0;
         r_sh_bright  <= '0;
         r_an         <= 8'hFF;
         r_seg        <= 7'h7F;
         r_dp         <= 1'b1;
         r_frame_tick <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_tick_cnt   <= w_tick_nxt;
         r_slot       <= w_slot_nxt;
         r_pwm_cnt    <= w_pwm_nxt;
         r_frame_tick <= w_frame_start;
         if (w_frame_start) begin
            r_sh_data   <= data_in;
            r_sh_dp     <= dp_in;
            r_sh_en     <= digit_en;
            r_sh_bright <= brightness;
         end
         r_an  <= w_lit ? ~(8'd1 << r_slot) : 8'hFF;
         r_seg <= w_lit ? hex_to_seg(w_nib) : 7'h7F;
         r_dp  <= w_lit ? ~r_sh_dp[r_slot] : 1'b1;
      end
   end

   assign AN         = r_an;
   assign SEG        = r_seg;
   assign DP         = r_dp;
   assign frame_tick = r_frame_tick;

endmodule
